stg_game_ctrl: RTL
==================

Name: stg_game_ctrl

Overview:
Parametrised top-level game-flow controller for the STG shooter. It tracks lives and bombs, sequences the game phases (title, ready, play, hit/invulnerable, bomb, pause, game over), and drives enables and status to the render, player, enemy and bullet blocks.
This generation adds over the fixed single-counter controller:
- configurable counts, maxima and timer lengths
- bomb and hit timers
- pause with resume-to-origin
- life/bomb pickups with saturation

Parameters:
LIFE_W, 4, width of the life counter
BOMB_W, 4, width of the bomb counter
INIT_LIFE, 3, lives loaded at game start and at reset
INIT_BOMB, 3, bombs loaded at game start and at reset
MAX_LIFE, 9, saturation limit for life pickups (INIT_LIFE <= MAX_LIFE < 2^LIFE_W)
MAX_BOMB, 9, saturation limit for bomb pickups (INIT_BOMB <= MAX_BOMB < 2^BOMB_W)
TMR_W, 32, phase timer width
START_CYC, 50000000, length of the ready phase in clk cycles (>=1)
INVULN_CYC, 20000000, length of the post-hit invulnerability in cycles (>=1)
BOMB_CYC, 10000000, length of the bomb effect in cycles (>=1)

Ports:
clk  in  1  system clock
hard_reset_n  in  1  asynchronous active-low reset
enter  in  1  start/confirm button level (pre-synchronised, debounced)
shift  in  1  bomb button level (pre-synchronised, debounced)
pause  in  1  pause button level (pre-synchronised, debounced)
collision  in  1  player hit, level, sampled each cycle
life_up  in  1  one-cycle life pickup pulse
bomb_up  in  1  one-cycle bomb pickup pulse
num_life  out  LIFE_W  current lives
num_bomb  out  BOMB_W  current bombs
game_state  out  4  state code
game_en  out  1  gameplay logic enable
game_reset  out  1  one-cycle pulse clearing the playfield blocks
invuln  out  1  player immune to collision
bomb_active  out  1  bomb effect active (clears enemy bullets)

Behaviour:
- Single clk domain. hard_reset_n low, at any time, asynchronously sets:
  - state IDLE, num_life=INIT_LIFE, num_bomb=INIT_BOMB
  - timer=0, ret_state=PLAY, edge registers=0
  - all 1-bit outputs 0
- All outputs are registered and change on the clk edge after the triggering input. Mid-game reset returns to IDLE immediately.
- Edge detection: each of enter/shift/pause has a prev register. x_pe = x & ~x_prev. Only rising edges act.
- State codes: IDLE 4'b0000, START 4'b0001, PLAY 4'b0010, PAUSE 4'b0011, BOMB 4'b0110, GAMEOVER 4'b1001, HIT 4'b1010.
- IDLE: game_en=0.
  - enter_pe -> START: load INIT_LIFE/INIT_BOMB, timer=START_CYC-1, game_reset=1 for exactly one cycle.
- START: game_en=0. Timer decrements each cycle; at timer==0 -> PLAY.
- PLAY: game_en=1. Per-cycle priority: collision > bomb > pause.
  - collision with num_life==1 -> GAMEOVER, num_life=0.
  - collision with num_life>1 -> HIT, num_life-1, timer=INVULN_CYC-1.
  - shift_pe with num_bomb>0 -> BOMB, num_bomb-1, timer=BOMB_CYC-1.
  - shift_pe with num_bomb==0: ignored.
  - pause_pe -> PAUSE, ret_state=PLAY.
- HIT: game_en=1, invuln=1. collision ignored, shift_pe ignored.
  - Timer decrements; at 0 -> PLAY.
  - pause_pe -> PAUSE, ret_state=HIT, timer held.
- BOMB: game_en=1, invuln=1, bomb_active=1. collision and shift_pe ignored.
  - Timer decrements; at 0 -> PLAY.
  - pause_pe -> PAUSE, ret_state=BOMB.
- PAUSE: game_en=0. Timer frozen. invuln/bomb_active hold the ret_state values. collision, pickups, shift and enter ignored.
  - pause_pe -> ret_state, resuming the remaining timer.
- GAMEOVER: game_en=0, num_life=0, num_bomb held. enter_pe -> IDLE.
- Pickups: accepted only in PLAY, HIT or BOMB.
  - life_up: num_life+1, saturating at MAX_LIFE.
  - bomb_up: num_bomb+1, saturating at MAX_BOMB.
- Simultaneous events:
  - life_up in the same cycle as an accepted collision is dropped.
  - bomb_up with an accepted bomb: num_bomb unchanged, state -> BOMB.
  - bomb_up with shift_pe and num_bomb==0: num_bomb=1, no bomb this cycle.
  - An event that fires on the cycle the timer hits 0 is evaluated next cycle, in PLAY.
- Timer arithmetic: unsigned TMR_W; never decrements below 0.

Test Plan:
1. Params START_CYC=4, INVULN_CYC=8, BOMB_CYC=5. Release reset, pulse enter -> game_reset high 1 cycle, START for 4 cycles, PLAY, num_life=3, num_bomb=3, game_en=1.
2. PLAY, assert collision 1 cycle -> HIT, num_life=2, invuln=1 for 8 cycles. Collision held during HIT -> no further decrement. Back to PLAY.
3. PLAY with num_life=1, collision -> GAMEOVER, num_life=0, game_en=0. enter pulse -> IDLE. enter again -> num_life=3, num_bomb=3.
4. shift edge x4 with gaps -> three BOMB phases of 5 cycles each, num_bomb 3->0. Fourth edge ignored, state stays PLAY. Held shift triggers only once.
5. In BOMB after 2 cycles, pulse pause -> PAUSE, bomb_active=1, timer frozen 20 cycles. Pulse pause -> BOMB resumes, exits after 3 more cycles.
6. Ten life_up pulses from 3 -> num_life saturates at 9. collision+life_up same cycle -> 8, HIT. Assert hard_reset_n low mid-HIT -> immediately IDLE, num_life=3, all flags 0.

Source files
------------

// File: rtl/stg_game_ctrl.sv
// STG game-flow controller: sequences title/ready/play/hit/bomb/pause/game-over
// phases, keeps life and bomb counts, and drives registered playfield enables.
module stg_game_ctrl #(
  parameter int LIFE_W     = 4,
  parameter int BOMB_W     = 4,
  parameter int INIT_LIFE  = 3,
  parameter int INIT_BOMB  = 3,
  parameter int MAX_LIFE   = 9,
  parameter int MAX_BOMB   = 9,
  parameter int TMR_W      = 32,
  parameter int START_CYC  = 50000000,
  parameter int INVULN_CYC = 20000000,
  parameter int BOMB_CYC   = 10000000
) (
  input  logic              clk,
  input  logic              hard_reset_n,
  input  logic              enter,
  input  logic              shift,
  input  logic              pause,
  input  logic              collision,
  input  logic              life_up,
  input  logic              bomb_up,
  output logic [LIFE_W-1:0] num_life,
  output logic [BOMB_W-1:0] num_bomb,
  output logic [3:0]        game_state,
  output logic              game_en,
  output logic              game_reset,
  output logic              invuln,
  output logic              bomb_active
);

  typedef enum logic [3:0] {
    IDLE     = 4'b0000,
    START    = 4'b0001,
    PLAY     = 4'b0010,
    PAUSE    = 4'b0011,
    BOMB     = 4'b0110,
    GAMEOVER = 4'b1001,
    HIT      = 4'b1010
  } state_e;

  localparam logic [LIFE_W-1:0] LIFE_INIT   = LIFE_W'(INIT_LIFE);
  localparam logic [LIFE_W-1:0] LIFE_MAX    = LIFE_W'(MAX_LIFE);
  localparam logic [LIFE_W-1:0] LIFE_ONE    = LIFE_W'(1);
  localparam logic [BOMB_W-1:0] BOMB_INIT   = BOMB_W'(INIT_BOMB);
  localparam logic [BOMB_W-1:0] BOMB_MAX    = BOMB_W'(MAX_BOMB);
  localparam logic [BOMB_W-1:0] BOMB_ONE    = BOMB_W'(1);
  localparam logic [TMR_W-1:0]  START_LOAD  = TMR_W'(START_CYC - 1);
  localparam logic [TMR_W-1:0]  INVULN_LOAD = TMR_W'(INVULN_CYC - 1);
  localparam logic [TMR_W-1:0]  BOMB_LOAD   = TMR_W'(BOMB_CYC - 1);
  localparam logic [TMR_W-1:0]  TMR_ONE     = TMR_W'(1);

  state_e            state_q, state_d;
  state_e            ret_q, ret_d;
  logic [LIFE_W-1:0] life_q, life_d;
  logic [BOMB_W-1:0] bomb_q, bomb_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              enter_prev_q, shift_prev_q, pause_prev_q;
  logic              game_en_q, game_en_d;
  logic              game_reset_q, game_reset_d;
  logic              invuln_q, invuln_d;
  logic              bomb_active_q, bomb_active_d;

  logic              enter_pe, shift_pe, pause_pe;
  logic [LIFE_W-1:0] life_sat_inc;
  logic [BOMB_W-1:0] bomb_sat_inc;

  assign enter_pe     = enter & ~enter_prev_q;
  assign shift_pe     = shift & ~shift_prev_q;
  assign pause_pe     = pause & ~pause_prev_q;
  assign life_sat_inc = (life_q >= LIFE_MAX) ? life_q : life_q + LIFE_ONE;
  assign bomb_sat_inc = (bomb_q >= BOMB_MAX) ? bomb_q : bomb_q + BOMB_ONE;

  always_ff @(posedge clk or negedge hard_reset_n) begin
    if (!hard_reset_n) begin
      state_q       <= IDLE;
      ret_q         <= PLAY;
      life_q        <= LIFE_INIT;
      bomb_q        <= BOMB_INIT;
      timer_q       <= '0;
      enter_prev_q  <= 1'b0;
      shift_prev_q  <= 1'b0;
      pause_prev_q  <= 1'b0;
      game_en_q     <= 1'b0;
      game_reset_q  <= 1'b0;
      invuln_q      <= 1'b0;
      bomb_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ret_q         <= ret_d;
      life_q        <= life_d;
      bomb_q        <= bomb_d;
      timer_q       <= timer_d;
      enter_prev_q  <= enter;
      shift_prev_q  <= shift;
      pause_prev_q  <= pause;
      game_en_q     <= game_en_d;
      game_reset_q  <= game_reset_d;
      invuln_q      <= invuln_d;
      bomb_active_q <= bomb_active_d;
    end
  end

  // Timer expiry beats a same-cycle pause so the phase ends cleanly in PLAY.
  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    life_d       = life_q;
    bomb_d       = bomb_q;
    timer_d      = timer_q;
    game_reset_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (enter_pe) begin
          state_d      = START;
          life_d       = LIFE_INIT;
          bomb_d       = BOMB_INIT;
          timer_d      = START_LOAD;
          game_reset_d = 1'b1;
        end
      end
      START: begin
        if (timer_q == '0) state_d = PLAY;
        else               timer_d = timer_q - TMR_ONE;
      end
      PLAY: begin
        if (collision) begin
          if (life_q <= LIFE_ONE) begin
            life_d  = '0;
            state_d = GAMEOVER;
          end else begin
            life_d  = life_q - LIFE_ONE;
            state_d = HIT;
            timer_d = INVULN_LOAD;
          end
          if (bomb_up) bomb_d = bomb_sat_inc;
        end else begin
          if (life_up) life_d = life_sat_inc;
          if (shift_pe && (bomb_q != '0)) begin
            state_d = BOMB;
            timer_d = BOMB_LOAD;
            if (!bomb_up) bomb_d = bomb_q - BOMB_ONE;
          end else begin
            if (bomb_up) bomb_d = bomb_sat_inc;
            if (pause_pe) begin
              state_d = PAUSE;
              ret_d   = PLAY;
            end
          end
        end
      end
      HIT, BOMB: begin
        if (life_up) life_d = life_sat_inc;
        if (bomb_up) bomb_d = bomb_sat_inc;
        if (timer_q == '0) begin
          state_d = PLAY;
        end else if (pause_pe) begin
          state_d = PAUSE;
          ret_d   = state_q;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end
      PAUSE: begin
        if (pause_pe) state_d = ret_q;
      end
      GAMEOVER: begin
        life_d = '0;
        if (enter_pe) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    game_en_d     = (state_d == PLAY) || (state_d == HIT) || (state_d == BOMB);
    invuln_d      = (state_d == HIT) || (state_d == BOMB) ||
                    ((state_d == PAUSE) && ((ret_d == HIT) || (ret_d == BOMB)));
    bomb_active_d = (state_d == BOMB) || ((state_d == PAUSE) && (ret_d == BOMB));
  end

  assign num_life    = life_q;
  assign num_bomb    = bomb_q;
  assign game_state  = state_q;
  assign game_en     = game_en_q;
  assign game_reset  = game_reset_q;
  assign invuln      = invuln_q;
  assign bomb_active = bomb_active_q;

endmodule
